mem_stage: RTL and testbench

- Memory-access stage of the 5-stage pipeline, between execute and writeback.
- Consumes exe_to_mem_t from execute and produces registered mem_to_wb_t for writeback.
- Drives a word-wide data-memory port with a req/gnt/rvalid protocol and back-pressures execute while an access is outstanding.
- ALU-only instructions pass through with 1-cycle latency.

---
 rtl/tartaruga_pkg.sv | 45 ++++
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tartaruga_pkg.sv
// Shared pipeline types for the tartaruga core: instruction fields, stage
// payloads and the memory-stage FSM encoding.
package tartaruga_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned FUNCT3_W        = 3;
    localparam int unsigned DMEM_WORD_BYTES = 4;

    typedef enum logic {
        ALU = 1'b0,
        MEM = 1'b1
    } alu_or_mem_t;

    // Decoded instruction fields carried down the pipeline
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  write_enable;
        alu_or_mem_t           alu_or_mem;
        logic                  store_to_mem;
        logic [FUNCT3_W-1:0]   funct3;
    } instr_t;

    // Execute -> memory payload
    typedef struct packed {
        instr_t            instr;
        logic [XLEN-1:0]   data_rs2;
        logic [XLEN-1:0]   result;
        logic              branch_taken;
    } exe_to_mem_t;

    // Memory -> writeback payload
    typedef struct packed {
        instr_t            instr;
        logic [XLEN-1:0]   result;
        logic              branch_taken;
    } mem_to_wb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// ALU ops retire one cycle after acceptance; loads/stores run a req/gnt/rvalid
// handshake on the data-memory port while ready_o holds execute off.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   exe_to_mem_i, valid_i  incoming instruction from execute
//   ready_o                stage can accept (combinational, IDLE only)
//   mem_to_wb_o, valid_o   registered result to writeback (1-cycle pulse)
//   dmem_*                 word-wide data-memory request/response port
//   misaligned_o           misaligned access flag, qualified by valid_o
//
// Optional feature: MEM_MISALIGN_CHECK_EN - when defined, misaligned memory ops
// are retired as faults without touching memory; otherwise the address is
// forced to word alignment and misaligned_o stays 0.
module mem_stage
    import tartaruga_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  exe_to_mem_t            exe_to_mem_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output mem_to_wb_t             mem_to_wb_o,
    output logic                   valid_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [DMEM_ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]        dmem_wdata_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [XLEN-1:0]        dmem_rdata_i,
    output logic                   misaligned_o
);

    mem_state_t      r_state;
    instr_t          r_instr;
    logic [XLEN-1:0] r_result;
    logic            r_branch;

    logic                   w_accept;
    logic                   w_is_mem;
    logic [DMEM_ADDR_W-1:0] w_addr;

    assign ready_o  = (r_state == IDLE);
    assign w_accept = valid_i && ready_o;
    assign w_is_mem = (exe_to_mem_i.instr.alu_or_mem == MEM) || exe_to_mem_i.instr.store_to_mem;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam int unsigned OFFSET_W = $clog2(DMEM_WORD_BYTES);

    logic   r_misaligned;
    logic   w_misaligned;
    instr_t w_fault_instr;

    assign w_addr       = DMEM_ADDR_W'(exe_to_mem_i.result);
    assign w_misaligned = |exe_to_mem_i.result[OFFSET_W-1:0];

    // A faulting access must not write the register file
    always_comb begin
        w_fault_instr              = r_instr;
        w_fault_instr.write_enable = 1'b0;
    end
`else
    localparam logic [DMEM_ADDR_W-1:0] OFFSET_MASK = DMEM_ADDR_W'(DMEM_WORD_BYTES - 1);

    // Byte offset dropped: the port is word addressed
    assign w_addr = DMEM_ADDR_W'(exe_to_mem_i.result) & ~OFFSET_MASK;
`endif

    // FSM, hold register, memory-port and writeback output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_instr      <= '0;
            r_result     <= '0;
            r_branch     <= 1'b0;
            mem_to_wb_o  <= '0;
            valid_o      <= 1'b0;
            misaligned_o <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            valid_o      <= 1'b0;
            misaligned_o <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem) begin
                            r_state      <= REQ;
                            r_instr      <= exe_to_mem_i.instr;
                            r_result     <= exe_to_mem_i.result;
                            r_branch     <= exe_to_mem_i.branch_taken;
                            dmem_we_o    <= exe_to_mem_i.instr.store_to_mem;
                            dmem_addr_o  <= w_addr;
                            dmem_wdata_o <= exe_to_mem_i.data_rs2;
`ifdef MEM_MISALIGN_CHECK_EN
                            r_misaligned <= w_misaligned;
                            dmem_req_o   <= !w_misaligned;
`else
                            dmem_req_o   <= 1'b1;
`endif
                        end else begin
                            valid_o                  <= 1'b1;
                            mem_to_wb_o.instr        <= exe_to_mem_i.instr;
                            mem_to_wb_o.result       <= exe_to_mem_i.result;
                            mem_to_wb_o.branch_taken <= exe_to_mem_i.branch_taken;
                        end
                    end
                end

                REQ: begin
`ifdef MEM_MISALIGN_CHECK_EN
                    if (r_misaligned) begin
                        r_state                  <= IDLE;
                        valid_o                  <= 1'b1;
                        misaligned_o             <= 1'b1;
                        mem_to_wb_o.instr        <= w_fault_instr;
                        mem_to_wb_o.result       <= r_result;
                        mem_to_wb_o.branch_taken <= r_branch;
                    end else
`endif
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (r_instr.store_to_mem) begin
                            r_state                  <= IDLE;
                            valid_o                  <= 1'b1;
                            mem_to_wb_o.instr        <= r_instr;
                            mem_to_wb_o.result       <= r_result;
                            mem_to_wb_o.branch_taken <= r_branch;
                        end else if (dmem_rvalid_i) begin
                            // Zero-latency response: skip WAIT_RESP
                            r_state                  <= IDLE;
                            valid_o                  <= 1'b1;
                            mem_to_wb_o.instr        <= r_instr;
                            mem_to_wb_o.result       <= dmem_rdata_i;
                            mem_to_wb_o.branch_taken <= r_branch;
                        end else begin
                            r_state <= WAIT_RESP;
                        end
                    end
                end

                WAIT_RESP: begin
                    if (dmem_rvalid_i) begin
                        r_state                  <= IDLE;
                        valid_o                  <= 1'b1;
                        mem_to_wb_o.instr        <= r_instr;
                        mem_to_wb_o.result       <= dmem_rdata_i;
                        mem_to_wb_o.branch_taken <= r_branch;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes,
// same-cycle gnt+rvalid, reset mid-access and misaligned addressing.
module tb_mem_stage;
    import tartaruga_pkg::*;

    logic        clk;
    logic        rstn;
    exe_to_mem_t exe;
    logic        valid_i;
    logic        ready_o;
    mem_to_wb_t  wb;
    logic        valid_o;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        misaligned;

    int n_pass  = 0;
    int n_total = 0;

    mem_stage #(.DMEM_ADDR_W(32)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .exe_to_mem_i (exe),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .mem_to_wb_o  (wb),
        .valid_o      (valid_o),
        .dmem_req_o   (req),
        .dmem_we_o    (we),
        .dmem_addr_o  (addr),
        .dmem_wdata_o (wdata),
        .dmem_gnt_i   (gnt),
        .dmem_rvalid_i(rvalid),
        .dmem_rdata_i (rdata),
        .misaligned_o (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exe_to_mem_t mk(input logic is_mem, input logic store, input logic wen,
                                       input logic [4:0] rd, input logic [31:0] rs2,
                                       input logic [31:0] res, input logic br);
        exe_to_mem_t e;
        e = '0;
        e.instr.alu_or_mem   = is_mem ? MEM : ALU;
        e.instr.store_to_mem = store;
        e.instr.write_enable = wen;
        e.instr.rd           = rd;
        e.instr.funct3       = 3'd2;
        e.data_rs2           = rs2;
        e.result             = res;
        e.branch_taken       = br;
        return e;
    endfunction

    initial begin
        rstn    = 1'b0;
        exe     = '0;
        valid_i = 1'b0;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        #22;
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_req", 64'(req), 64'(0));
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_addr", 64'(addr), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_wb", 64'(wb), 64'(0));
        chk("rst_mis", 64'(misaligned), 64'(0));
        chk("rst_ready", 64'(ready_o), 64'(1));
        rstn = 1'b1;

        // ALU op: one-cycle pass-through
        step();
        exe     = mk(1'b0, 1'b0, 1'b1, 5'd5, 32'hFFFF_0000, 32'h0000_0042, 1'b0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("alu_valid", 64'(valid_o), 64'(1));
        chk("alu_result", 64'(wb.result), 64'h42);
        chk("alu_rd", 64'(wb.instr.rd), 64'd5);
        chk("alu_we", 64'(wb.instr.write_enable), 64'(1));
        chk("alu_noreq", 64'(req), 64'(0));
        step();
        chk("alu_pulse", 64'(valid_o), 64'(0));
        chk("alu_noreq2", 64'(req), 64'(0));

        // Load: gnt on the third REQ cycle, rvalid a few cycles later
        exe     = mk(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0000_0100, 1'b0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("ld_req1", 64'(req), 64'(1));
        chk("ld_we", 64'(we), 64'(0));
        chk("ld_addr1", 64'(addr), 64'h100);
        chk("ld_ready1", 64'(ready_o), 64'(0));
        step();
        chk("ld_req2", 64'(req), 64'(1));
        chk("ld_addr2", 64'(addr), 64'h100);
        step();
        chk("ld_req3", 64'(req), 64'(1));
        chk("ld_addr3", 64'(addr), 64'h100);
        chk("ld_ready3", 64'(ready_o), 64'(0));
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("ld_wait_req", 64'(req), 64'(0));
        chk("ld_wait_ready", 64'(ready_o), 64'(0));
        step();
        chk("ld_wait_valid", 64'(valid_o), 64'(0));
        step();
        chk("ld_wait_ready2", 64'(ready_o), 64'(0));
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        rdata  = '0;
        chk("ld_valid", 64'(valid_o), 64'(1));
        chk("ld_result", 64'(wb.result), 64'hDEAD_BEEF);
        chk("ld_rd", 64'(wb.instr.rd), 64'd3);
        chk("ld_ready_back", 64'(ready_o), 64'(1));
        step();
        chk("ld_pulse", 64'(valid_o), 64'(0));

        // Store with immediate gnt
        exe     = mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h1234_5678, 32'h0000_0204, 1'b0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("st_req", 64'(req), 64'(1));
        chk("st_we", 64'(we), 64'(1));
        chk("st_addr", 64'(addr), 64'h204);
        chk("st_wdata", 64'(wdata), 64'h1234_5678);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("st_valid", 64'(valid_o), 64'(1));
        chk("st_result", 64'(wb.result), 64'h204);
        chk("st_store_fwd", 64'(wb.instr.store_to_mem), 64'(1));
        chk("st_req_drop", 64'(req), 64'(0));

        // Load with gnt and rvalid together, then back-to-back ALU op
        exe     = mk(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0000_0300, 1'b1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("fast_req", 64'(req), 64'(1));
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hA5A5_A5A5;
        step();
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        chk("fast_valid", 64'(valid_o), 64'(1));
        chk("fast_result", 64'(wb.result), 64'hA5A5_A5A5);
        chk("fast_branch", 64'(wb.branch_taken), 64'(1));
        chk("fast_ready", 64'(ready_o), 64'(1));
        exe     = mk(1'b0, 1'b0, 1'b1, 5'd9, 32'h0, 32'h0000_0077, 1'b1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("b2b_valid", 64'(valid_o), 64'(1));
        chk("b2b_result", 64'(wb.result), 64'h77);
        chk("b2b_rd", 64'(wb.instr.rd), 64'd9);

        // Reset while in WAIT_RESP, then a stale rvalid
        exe     = mk(1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0000_0400, 1'b0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        gnt     = 1'b1;
        step();
        gnt = 1'b0;
        chk("rw_wait_ready", 64'(ready_o), 64'(0));
        rstn = 1'b0;
        #1;
        chk("rw_req", 64'(req), 64'(0));
        chk("rw_valid", 64'(valid_o), 64'(0));
        chk("rw_ready", 64'(ready_o), 64'(1));
        #2;
        rstn = 1'b1;
        step();
        rvalid = 1'b1;
        rdata  = 32'h0000_0BAD;
        step();
        rvalid = 1'b0;
        chk("rw_stale_valid", 64'(valid_o), 64'(0));
        step();
        chk("rw_stale_valid2", 64'(valid_o), 64'(0));
        chk("rw_ready2", 64'(ready_o), 64'(1));

        // Misaligned load at 0x102
        exe     = mk(1'b1, 1'b0, 1'b1, 5'd6, 32'h0, 32'h0000_0102, 1'b0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_noreq", 64'(req), 64'(0));
        chk("mis_valid0", 64'(valid_o), 64'(0));
        step();
        chk("mis_valid", 64'(valid_o), 64'(1));
        chk("mis_flag", 64'(misaligned), 64'(1));
        chk("mis_wen", 64'(wb.instr.write_enable), 64'(0));
        chk("mis_result", 64'(wb.result), 64'h102);
        chk("mis_noreq2", 64'(req), 64'(0));
`else
        chk("mis_req", 64'(req), 64'(1));
        chk("mis_addr", 64'(addr), 64'h100);
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h0000_0055;
        step();
        gnt    = 1'b0;
        rvalid = 1'b0;
        chk("mis_valid", 64'(valid_o), 64'(1));
        chk("mis_flag", 64'(misaligned), 64'(0));
        chk("mis_result", 64'(wb.result), 64'h55);
        chk("mis_wen", 64'(wb.instr.write_enable), 64'(1));
`endif
        step();
        chk("end_valid", 64'(valid_o), 64'(0));
        chk("end_ready", 64'(ready_o), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
